// File: rtl/adc_spi_reader.sv
// Periodic reader for a 16-clock, MSB-first serial ADC frame. It drives cs/s_clk,
// shifts in one conversion per period, and flags frames whose lead bits are not zero.
module adc_spi_reader #(
  parameter int CLK_DIV       = 6,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_BITS     = 4,
  parameter int DATA_BITS     = 12,
  parameter int SAMPLE_PERIOD = 1200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 s_data,
  output logic                 s_clk,
  output logic                 cs,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 lead_err,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WAIT} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [PER_W-1:0]     per_q, per_d;
  logic                 hi_q, hi_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 err_q, err_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 lead_err_q, lead_err_d;
  logic                 busy_q, busy_d;
  logic                 div_tick;

  assign div_tick = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    hi_d       = hi_q;
    shreg_d    = shreg_q;
    err_d      = err_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    sample_d   = sample_q;
    lead_err_d = lead_err_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    // The period counter free-runs from the cs falling edge so the frame rate is jitter-free.
    per_d      = (state_q == IDLE) ? per_q : per_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          per_d   = '0;
          div_d   = '0;
          shreg_d = '0;
          err_d   = 1'b0;
        end
      end
      SETUP: begin
        if (div_tick) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_tick) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!hi_q) begin
            // s_data is captured on the same edge that raises s_clk.
            sclk_d = 1'b1;
            hi_d   = 1'b1;
            if (int'(bit_q) < LEAD_BITS) begin
              err_d = err_q | s_data;
            end else if (int'(bit_q) < LEAD_BITS + DATA_BITS) begin
              shreg_d = {shreg_q[DATA_BITS-2:0], s_data};
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b0;
            hi_d   = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_tick) begin
          state_d    = WAIT;
          div_d      = '0;
          cs_d       = 1'b1;
          busy_d     = 1'b0;
          sample_d   = shreg_q;
          lead_err_d = err_q;
          valid_d    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      WAIT: begin
        if (per_q == PER_LAST) begin
          per_d = '0;
          if (en) begin
            state_d = SETUP;
            cs_d    = 1'b0;
            busy_d  = 1'b1;
            div_d   = '0;
            shreg_d = '0;
            err_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      per_q      <= '0;
      hi_q       <= 1'b0;
      shreg_q    <= '0;
      err_q      <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b1;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      lead_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      per_q      <= per_d;
      hi_q       <= hi_d;
      shreg_q    <= shreg_d;
      err_q      <= err_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      lead_err_q <= lead_err_d;
      busy_q     <= busy_d;
    end
  end

  assign cs           = cs_q;
  assign s_clk        = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign lead_err     = lead_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: a default instance and a fast one (CLK_DIV=1, period 35),
// each fed by an ADC model, with a scoreboard checking every strobe and cs edge.
module tb_adc_spi_reader;

  logic clk;
  logic rst;
  logic en0, en1;
  logic s_data0, s_data1;
  logic s_clk0, s_clk1, cs0, cs1, valid0, valid1, lead0, lead1, busy0, busy1;
  logic [11:0] sample0, sample1;

  adc_spi_reader u_dut (
    .clk(clk), .rst(rst), .en(en0), .s_data(s_data0), .s_clk(s_clk0), .cs(cs0),
    .sample(sample0), .sample_valid(valid0), .lead_err(lead0), .busy(busy0)
  );

  adc_spi_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(35)) u_fast (
    .clk(clk), .rst(rst), .en(en1), .s_data(s_data1), .s_clk(s_clk1), .cs(cs1),
    .sample(sample1), .sample_valid(valid1), .lead_err(lead1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    logic [11:0] sample;
    logic        lead;
    int          due;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;
  bit stim_timeout = 1'b0;

  int  sp[2] = '{1200, 35};
  int  cd[2] = '{6, 1};
  int  t0[2], exp_fall[2], idle_from[2], falls[2], frames[2];
  bit  model_idle[2], have_t0[2], prev_cs[2], prev_sclk[2], prev_valid[2];
  logic [11:0] last_sample[2];
  logic [15:0] word[2];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Frame contents: three directed words on the default instance, then random,
  // with the lead nibble usually clear so both lead_err values are exercised.
  function automatic logic [15:0] pick(input int i, input int n);
    logic [15:0] w;
    if (i == 0 && n == 0) return 16'h0A5C;
    if (i == 0 && n == 1) return 16'hFFFF;
    if (i == 0 && n == 2) return 16'h0000;
    w = 16'($urandom);
    if ($urandom_range(3) != 0) w[15:12] = 4'h0;
    return w;
  endfunction

  task automatic step(input int i);
    logic c, sk, v, le, b, e;
    logic [11:0] s;
    bit fell;
    int idx;
    exp_t ex;
    c  = (i == 0) ? cs0 : cs1;
    sk = (i == 0) ? s_clk0 : s_clk1;
    v  = (i == 0) ? valid0 : valid1;
    le = (i == 0) ? lead0 : lead1;
    b  = (i == 0) ? busy0 : busy1;
    e  = (i == 0) ? en0 : en1;
    s  = (i == 0) ? sample0 : sample1;

    if (rst) begin
      check("rst_cs", c, 1);
      check("rst_sclk", sk, 1);
      check("rst_sample", s, 0);
      check("rst_valid", v, 0);
      check("rst_lead_err", le, 0);
      check("rst_busy", b, 0);
      for (int k = sb.size() - 1; k >= 0; k--)
        if (sb[k].inst == i) sb.delete(k);
      model_idle[i]  = 1'b1;
      idle_from[i]   = 0;
      exp_fall[i]    = -1;
      have_t0[i]     = 1'b0;
      prev_cs[i]     = 1'b1;
      prev_sclk[i]   = 1'b1;
      prev_valid[i]  = 1'b0;
      last_sample[i] = '0;
      falls[i]       = 0;
      return;
    end

    fell = prev_cs[i] && !c;
    if (fell) begin
      check("cs_fall_cycle", cyc, exp_fall[i]);
      exp_fall[i] = -1;
      t0[i]       = cyc;
      have_t0[i]  = 1'b1;
      falls[i]    = 0;
      word[i]     = pick(i, frames[i]);
      frames[i]++;
      ex.inst   = i;
      ex.sample = word[i][11:0];
      ex.lead   = (word[i][15:12] != 4'h0);
      ex.due    = cyc + 34 * cd[i];
      sb.push_back(ex);
    end else if (exp_fall[i] >= 0 && cyc == exp_fall[i]) begin
      check("cs_fall_missing", 0, 1);
      exp_fall[i] = -1;
    end

    // ADC model: each s_clk falling edge presents the next frame bit, MSB first.
    if (prev_sclk[i] && !sk) begin
      if (falls[i] < 16) begin
        if (i == 0) s_data0 = word[i][15 - falls[i]];
        else        s_data1 = word[i][15 - falls[i]];
      end
      falls[i]++;
    end

    if (c && !sk) check("sclk_idle_high", sk, 1);
    if (b == c)   check("busy_vs_cs", b, !c);

    if (v) begin
      if (prev_valid[i]) check("strobe_width", 2, 1);
      idx = -1;
      for (int k = 0; k < sb.size(); k++)
        if (idx < 0 && sb[k].inst == i) idx = k;
      if (idx < 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        check("sample", s, sb[idx].sample);
        check("lead_err", le, sb[idx].lead);
        check("strobe_cycle", cyc, sb[idx].due);
        check("cs_high_at_strobe", c, 1);
        check("sclk_falls", falls[i], 16);
        sb.delete(idx);
      end
      last_sample[i] = s;
    end else if (s != last_sample[i]) begin
      check("sample_hold", s, last_sample[i]);
    end

    if (have_t0[i] && cyc == t0[i] + sp[i] - 1) begin
      if (e) exp_fall[i] = cyc + 1;
      else begin
        model_idle[i] = 1'b1;
        idle_from[i]  = cyc + 1;
      end
    end else if (model_idle[i] && cyc >= idle_from[i] && e) begin
      exp_fall[i]   = cyc + 1;
      model_idle[i] = 1'b0;
    end

    prev_cs[i]    = c;
    prev_sclk[i]  = sk;
    prev_valid[i] = v;
  endtask

  initial begin
    s_data0 = 1'b0;
    s_data1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frames[i]     = 0;
      exp_fall[i]   = -1;
      model_idle[i] = 1'b1;
      idle_from[i]  = 0;
      have_t0[i]    = 1'b0;
      prev_cs[i]    = 1'b1;
      prev_sclk[i]  = 1'b1;
      prev_valid[i] = 1'b0;
      falls[i]      = 0;
      word[i]       = '0;
      last_sample[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (done) break;
      for (int i = 0; i < 2; i++) step(i);
    end
    foreach (sb[k]) check("strobe_missing", sb[k].inst, -1);
    check("stim_timeout", stim_timeout, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic wait_frames(input int n, input int limit);
    int k = 0;
    while (frames[0] < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (frames[0] < n) stim_timeout = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    // Eight back-to-back frames, then drop en about 50 cycles into the eighth.
    wait_frames(8, 12000);
    repeat (49) @(posedge clk);
    #1 en0 = 1'b0;
    repeat (1500) @(posedge clk);
    #1 en0 = 1'b1;
    // Reset about 100 cycles into a frame, then let conversions resume.
    wait_frames(10, 3000);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2600) @(posedge clk);
    #1;
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (1500) @(posedge clk);
    done = 1'b1;
  end

endmodule
